// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: fetches over a req/ready handshake, holds the
// word in an instruction register and issues a one-cycle run strobe per word.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'h0000_0073,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] INSTRin_o,
    output logic        run,
    input  logic        PCSrc,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] instret,
    output logic        halted,
    output logic [1:0]  err
);
    // state | meaning
    // IDLE  | waiting for start, pc parked at RESET_PC, err cleared
    // FETCH | imem_req high until handshake or timeout
    // EXEC  | single-cycle run strobe, pc update
    // HALT  | stopped on ecall or error until start drops
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_imem_req;
    logic        r_run;
    logic        r_halted;
    logic [1:0]  r_err;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instret;
    logic [7:0]  r_tmo_cnt;

    logic        w_hs;
    logic        w_tmo;
    logic        w_misalign;
    logic [31:0] w_next_pc;
    logic        w_req_nxt;
    logic        w_run_nxt;
    logic        w_halted_nxt;

    assign w_hs       = (r_state == FETCH) && r_imem_req && imem_ready;
    assign w_tmo      = (r_tmo_cnt == TMO_LAST);
    assign w_misalign = PCSrc && (branch_target[1:0] != 2'b00);
    assign w_next_pc  = PCSrc ? branch_target : (r_pc + 32'd4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = FETCH;
            end
            FETCH: begin
                if (w_hs) begin
                    w_state_nxt = (imem_rdata == HALT_INSTR) ? HALT : EXEC;
                end else if (w_tmo) begin
                    w_state_nxt = HALT;
                end
            end
            EXEC: begin
                if (w_misalign)  w_state_nxt = HALT;
                else if (start)  w_state_nxt = FETCH;
                else             w_state_nxt = IDLE;
            end
            HALT: begin
                if (!start) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they leave a flop.
    always_comb begin
        w_req_nxt    = (w_state_nxt == FETCH);
        w_run_nxt    = (w_state_nxt == EXEC);
        w_halted_nxt = (w_state_nxt == HALT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_imem_req <= 1'b0;
            r_run      <= 1'b0;
            r_halted   <= 1'b0;
            r_err      <= 2'b00;
            r_pc       <= RESET_PC;
            r_instr    <= 32'd0;
            r_instret  <= 32'd0;
            r_tmo_cnt  <= 8'd0;
        end else begin
            r_imem_req <= w_req_nxt;
            r_run      <= w_run_nxt;
            r_halted   <= w_halted_nxt;

            if (w_hs) r_instr <= imem_rdata;

            if (r_state != FETCH)  r_tmo_cnt <= 8'd0;
            else if (!imem_ready)  r_tmo_cnt <= r_tmo_cnt + 8'd1;

            if (w_state_nxt == IDLE) begin
                r_err <= 2'b00;
            end else if ((r_state == FETCH) && !w_hs && w_tmo) begin
                r_err <= 2'b01;
            end else if ((r_state == EXEC) && w_misalign) begin
                r_err <= 2'b10;
            end

            if (w_state_nxt == IDLE) begin
                r_pc <= RESET_PC;
            end else if ((r_state == EXEC) && !w_misalign) begin
                r_pc <= w_next_pc;
            end

            if ((r_state == EXEC) && !w_misalign) r_instret <= r_instret + 32'd1;
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;
    assign INSTRin_o = r_instr;
    assign run       = r_run;
    assign pc        = r_pc;
    assign instret   = r_instret;
    assign halted    = r_halted;
    assign err       = r_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a tiny memory model answers fetches,
// every expected value below is worked out by hand from the cycle timeline.
module tb_instr_fetch_unit;
    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] INSTRin_o;
    logic        run;
    logic        PCSrc;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [31:0] instret;
    logic        halted;
    logic [1:0]  err;

    logic        ready_en;
    logic [31:0] halt_at;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    // Memory returns the ecall word only at halt_at, an addi everywhere else.
    assign imem_ready = ready_en;
    assign imem_rdata = (imem_addr == halt_at) ? ECALL : ADDI;

    instr_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .INSTRin_o     (INSTRin_o),
        .run           (run),
        .PCSrc         (PCSrc),
        .branch_target (branch_target),
        .pc            (pc),
        .instret       (instret),
        .halted        (halted),
        .err           (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; ready_en = 1'b1;
        PCSrc = 1'b0; branch_target = 32'd0; halt_at = 32'h8;
        #12;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_run", 32'(run), 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_instr", INSTRin_o, 32'd0);
        reset = 1'b1; start = 1'b1;

        // zero-wait fetches at 0 and 4, ecall at 8
        tick();
        check("t1_req", 32'(imem_req), 32'd1);
        check("t1_addr0", imem_addr, 32'd0);
        check("t1_norun", 32'(run), 32'd0);
        tick();
        check("t1_run1", 32'(run), 32'd1);
        check("t1_instr1", INSTRin_o, ADDI);
        check("t1_pc_exec", pc, 32'd0);
        tick();
        check("t1_run_gap", 32'(run), 32'd0);
        check("t1_pc4", pc, 32'd4);
        check("t1_addr4", imem_addr, 32'd4);
        check("t1_instret1", instret, 32'd1);
        tick();
        check("t1_run2", 32'(run), 32'd1);
        check("t1_instr2", INSTRin_o, ADDI);
        tick();
        check("t1_pc8", pc, 32'd8);
        check("t1_instret2", instret, 32'd2);
        tick();
        check("t3_halted", 32'(halted), 32'd1);
        check("t3_norun", 32'(run), 32'd0);
        check("t3_pc", pc, 32'd8);
        check("t3_instret", instret, 32'd2);
        check("t3_req", 32'(imem_req), 32'd0);
        check("t3_instr", INSTRin_o, ECALL);
        tick();
        check("t3_hold", 32'(halted), 32'd1);
        start = 1'b0;
        tick();
        check("t3_idle_halted", 32'(halted), 32'd0);
        check("t3_idle_pc", pc, 32'd0);

        // branch to 0x40, branch to 0xFFFFFFFC, then sequential wrap to 0
        halt_at = 32'hFFFF_FFF0;
        start = 1'b1; PCSrc = 1'b1; branch_target = 32'h40;
        tick();
        tick();
        check("t2_run", 32'(run), 32'd1);
        tick();
        check("t2_pc_br", pc, 32'h40);
        check("t2_addr_br", imem_addr, 32'h40);
        branch_target = 32'hFFFF_FFFC;
        tick();
        tick();
        check("t2_pc_top", pc, 32'hFFFF_FFFC);
        PCSrc = 1'b0;
        tick();
        tick();
        check("t2_pc_wrap", pc, 32'd0);
        check("t2_instret", instret, 32'd5);

        // misaligned branch target
        PCSrc = 1'b1; branch_target = 32'h102;
        tick();
        tick();
        check("t5_err", 32'(err), 32'd2);
        check("t5_halted", 32'(halted), 32'd1);
        check("t5_pc", pc, 32'd0);
        check("t5_instret", instret, 32'd5);
        check("t5_norun", 32'(run), 32'd0);
        start = 1'b0; PCSrc = 1'b0;
        tick();
        check("t5_err_clr", 32'(err), 32'd0);
        check("t5_idle", 32'(halted), 32'd0);

        // memory never ready: 16 fetch cycles then timeout
        ready_en = 1'b0; start = 1'b1;
        tick();
        repeat (15) tick();
        check("t4_still_req", 32'(imem_req), 32'd1);
        check("t4_not_halted", 32'(halted), 32'd0);
        check("t4_no_err", 32'(err), 32'd0);
        tick();
        check("t4_halted", 32'(halted), 32'd1);
        check("t4_err", 32'(err), 32'd1);
        check("t4_req_off", 32'(imem_req), 32'd0);
        ready_en = 1'b1;
        tick();
        check("t4_late_halted", 32'(halted), 32'd1);
        check("t4_late_instr", INSTRin_o, ADDI);
        check("t4_late_instret", instret, 32'd5);
        check("t4_late_run", 32'(run), 32'd0);
        start = 1'b0;
        tick();
        check("t4_err_clr", 32'(err), 32'd0);

        // reset mid-fetch after 3 wait states
        ready_en = 1'b0; start = 1'b1;
        tick();
        tick();
        tick();
        check("t6_req_before", 32'(imem_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_req_drop", 32'(imem_req), 32'd0);
        check("t6_pc", pc, 32'd0);
        check("t6_instret", instret, 32'd0);
        check("t6_halted", 32'(halted), 32'd0);
        ready_en = 1'b1;
        tick();
        start = 1'b0;
        reset = 1'b1;
        tick();
        check("t6_idle_req", 32'(imem_req), 32'd0);
        check("t6_idle_run", 32'(run), 32'd0);
        check("t6_idle_instr", INSTRin_o, 32'd0);
        start = 1'b1;
        tick();
        check("t6_restart_req", 32'(imem_req), 32'd1);
        check("t6_restart_addr", imem_addr, 32'd0);
        tick();
        check("t6_restart_run", 32'(run), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
